run_detect: RTL and testbench
=============================

# run_detect

Multi-channel, parametrised run-length detector. Each channel watches one input bit and emits a one-cycle pulse once that bit has been sampled active for a programmable number of consecutive clock edges. A channel cannot fire again until its input returns inactive. Used as the qualified-edge / debounce front end ahead of control FSMs. With a run length of 1 and positive polarity, it reduces to the single-bit rising-edge pulse FSM.

## Interface
Parameters:
- CH, 4: number of independent channels (≥1).
- RUN_MAX, 15: largest supported run length (≥1). Counter width CW = $clog2(RUN_MAX+1).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- i  input  CH  per-channel raw input, sampled on posedge clk.
- pol  input  CH  per-channel polarity: 0 = detect run of 1s, 1 = detect run of 0s. Effective input a[k] = i[k] ^ pol[k].
- run_len  input  CW  required run length, shared by all channels.
- q  output  CH  per-channel one-cycle detect pulse, registered (Moore).
- qf  output  CH  per-channel release pulse; present only with RUN_DETECT_FALL_EN.

## Operation
- Effective run length: L = 1 if run_len==0; RUN_MAX if run_len>RUN_MAX; run_len otherwise.
- Each channel latches L into a private register lk on the IDLE→COUNT transition. A change to run_len mid-run does not affect a run in progress.
- Per-channel states: IDLE, COUNT, FIRE, HOLD, plus REL when the macro is defined.
- Counter: cnt, CW bits. It never exceeds lk, so no wrap is possible.
- Transitions (a = effective input sampled this edge):
  - IDLE:
    - a=1 and L==1 → FIRE.
    - a=1 and L>1 → COUNT, cnt=1, lk=L.
    - a=0 → IDLE.
  - COUNT:
    - a=0 → IDLE, cnt=0.
    - a=1 and cnt+1==lk → FIRE.
    - a=1 otherwise → COUNT, cnt+1.
  - FIRE:
    - a=1 → HOLD.
    - a=0 → IDLE (REL with macro).
  - HOLD:
    - a=1 → HOLD.
    - a=0 → IDLE (REL with macro).
  - REL: treated exactly as IDLE for the next-state decision.
- Outputs: q[k]=1 only in FIRE. qf[k]=1 only in REL.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Toggling pol[k] flips a[k] and is treated as an ordinary input change.

## Timing
- Reset asserted (any time, including mid-run): all channels go to IDLE; cnt=0; lk=1; q=0; qf=0. No pulse is emitted on reset release.
- Latency: q[k] rises in the cycle after the edge that samples the L-th consecutive active value. For L=1, that is one cycle after the first active sample.
- Pulse width: q is exactly 1 cycle per qualified run, even if the input stays active indefinitely.
- A run broken one sample short of L produces no pulse. The count restarts from 0.
- Minimum re-fire spacing: one inactive sample followed by L active samples.
- qf rises in the cycle after the first inactive sample following FIRE/HOLD. Its width is 1 cycle.

## Configuration
- RUN_DETECT_FALL_EN defined:
  - REL state and qf port exist.
  - A run that fired produces a qf pulse when it ends.
  - Runs that never reached L produce no qf.
- Not defined:
  - No qf port, no REL state.
  - FIRE/HOLD return directly to IDLE on an inactive sample.

## Structure
- Package run_detect_pkg holds:
  - the state enum typedef (IDLE, COUNT, FIRE, HOLD, REL);
  - the encoding localparams.
- CW is derived locally from RUN_MAX.
- Sub-module run_detect_ch implements one channel (FSM, cnt, lk) with RUN_MAX as its parameter. run_detect clamps run_len once and generates CH instances.

## Test plan
- CH=4, RUN_MAX=15, run_len=1, pol=0; i[0] pattern 0,1,1,1,0 → q[0]=1 only in the cycle after the first 1; q[3:1]=0.
- run_len=3, i[1] active for 2 edges, low, then active for 5 edges → no pulse on the first run; q[1] pulses once, one cycle after the 3rd active sample of the second run.
- run_len=0 → behaves as 1. run_len=15 with RUN_MAX=7 → needs 7 samples. Change run_len 3→6 mid-COUNT → current run still fires at 3.
- pol[2]=1, i[2] held 0 for 4 edges with run_len=4 → single q[2] pulse. i[0] pattern applied at the same time on channel 0 → independent pulses with no cross-talk.
- Assert reset in COUNT with cnt=2 and again in HOLD → q=0 and qf=0 immediately. After release, a full L-run is required before the next pulse.
- With RUN_DETECT_FALL_EN, run_len=2, pattern 1,1,1,0 → q pulse and then a qf pulse one cycle after the 0 sample. Pattern 1,0 → no q and no qf.

Source files
------------

// File: rtl/run_detect_pkg.sv
// run_detect_pkg: shared state encoding for the run-length detector channels.
`default_nettype none

package run_detect_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_COUNT = 3'd1;
  localparam logic [ST_W-1:0] ST_FIRE  = 3'd2;
  localparam logic [ST_W-1:0] ST_HOLD  = 3'd3;
  localparam logic [ST_W-1:0] ST_REL   = 3'd4;

  typedef enum logic [ST_W-1:0] {
    IDLE  = ST_IDLE,
    COUNT = ST_COUNT,
    FIRE  = ST_FIRE,
    HOLD  = ST_HOLD,
    REL   = ST_REL
  } state_t;

endpackage

`default_nettype wire

// File: rtl/run_detect_ch.sv
// run_detect_ch: one run-length detector channel (FSM, run counter, latched length).
// Release state and qf output exist only when RUN_DETECT_FALL_EN is defined.
`default_nettype none

module run_detect_ch
  import run_detect_pkg::*;
#(
  parameter  int RUN_MAX = 15,
  localparam int CW      = $clog2(RUN_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a,
  input  logic [CW-1:0] len,
  output logic          q
`ifdef RUN_DETECT_FALL_EN
  ,
  output logic          qf
`endif
);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] lk, lk_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      lk    <= CW'(1);
      q     <= 1'b0;
`ifdef RUN_DETECT_FALL_EN
      qf    <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      lk    <= lk_n;
      q     <= (state_n == FIRE);
`ifdef RUN_DETECT_FALL_EN
      qf    <= (state_n == REL);
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lk_n    = lk;
    case (state)
      IDLE, REL: begin
        cnt_n = '0;
        if (!a) begin
          state_n = IDLE;
        end else if (len == CW'(1)) begin
          state_n = FIRE;
        end else begin
          // Length is captured here so a run_len change cannot disturb this run.
          state_n = COUNT;
          cnt_n   = CW'(1);
          lk_n    = len;
        end
      end
      COUNT: begin
        if (!a) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt + CW'(1) == lk) begin
          state_n = FIRE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      FIRE, HOLD: begin
        if (a) begin
          state_n = HOLD;
        end else begin
`ifdef RUN_DETECT_FALL_EN
          state_n = REL;
`else
          state_n = IDLE;
`endif
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/run_detect.sv
// run_detect: CH-channel run-length detector; clamps run_len once and fans out to channels.
// Optional release pulses (qf) are built when RUN_DETECT_FALL_EN is defined.
`default_nettype none

module run_detect
  import run_detect_pkg::*;
#(
  parameter  int CH      = 4,
  parameter  int RUN_MAX = 15,
  localparam int CW      = $clog2(RUN_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] i,
  input  logic [CH-1:0] pol,
  input  logic [CW-1:0] run_len,
  output logic [CH-1:0] q
`ifdef RUN_DETECT_FALL_EN
  ,
  output logic [CH-1:0] qf
`endif
);

  localparam logic [CW-1:0] LEN_MAX = CW'(RUN_MAX);

  logic [CH-1:0] a;
  logic [CW-1:0] len;

  assign a = i ^ pol;

  // Zero means "single sample"; values past RUN_MAX saturate.
  always_comb begin
    len = run_len;
    if (run_len == '0) begin
      len = CW'(1);
    end else if (run_len > LEN_MAX) begin
      len = LEN_MAX;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    run_detect_ch #(
      .RUN_MAX (RUN_MAX)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .a     (a[k]),
      .len   (len),
      .q     (q[k])
`ifdef RUN_DETECT_FALL_EN
      ,
      .qf    (qf[k])
`endif
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_run_detect.sv
// tb_run_detect: scoreboard bench for run_detect; qf checks are active with RUN_DETECT_FALL_EN.
`default_nettype none

module tb_run_detect;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] i;
  logic [3:0] pol;
  logic [3:0] run_len;
  logic [3:0] q;
  logic [3:0] qf;

  logic       i2;
  logic [3:0] run_len2;
  logic       q2;
  logic       qf2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] q;
    logic [3:0] qf;
    string      tag;
  } exp_t;

  exp_t sb[$];
  logic sb2[$];

  always #5 clk = ~clk;

  run_detect #(.CH(4), .RUN_MAX(15)) dut (
    .clk     (clk),
    .reset   (reset),
    .i       (i),
    .pol     (pol),
    .run_len (run_len),
    .q       (q)
`ifdef RUN_DETECT_FALL_EN
    ,
    .qf      (qf)
`endif
  );

  // Non-power-of-two RUN_MAX so that run_len can exceed it and exercise saturation.
  run_detect #(.CH(1), .RUN_MAX(10)) dut2 (
    .clk     (clk),
    .reset   (reset),
    .i       (i2),
    .pol     (1'b0),
    .run_len (run_len2),
    .q       (q2)
`ifdef RUN_DETECT_FALL_EN
    ,
    .qf      (qf2)
`endif
  );

`ifndef RUN_DETECT_FALL_EN
  assign qf  = 4'h0;
  assign qf2 = 1'b0;
`endif

  // Drive one sample, record what must be seen after the sampling edge.
  task automatic drive(input logic [3:0] iv, input logic [3:0] eq, input logic [3:0] ef,
                       input string tag);
    exp_t e;
    i = iv;
    e.q = eq;
    e.qf = ef;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i = 4'h0; pol = 4'h0; run_len = 4'd1; i2 = 1'b0; run_len2 = 4'd15;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (q !== 4'h0 || q2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_q: q=%b q2=%b required 0000/0", q, q2);
    end
`ifdef RUN_DETECT_FALL_EN
    n_checks++;
    if (qf !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_qf: qf=%b required 0000", qf);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_len1();
    logic [3:0] iv [6] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
    logic [3:0] eq [6] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] ef [6] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    exp_t e;
    run_len = 4'd1; pol = 4'h0;
    for (int k = 0; k < 6; k++) begin
      drive(iv[k], eq[k], ef[k], "len1");
      e = sb.pop_front();
      n_checks++;
      if (q !== e.q) begin
        n_fail++;
        $display("FAIL %s step %0d: q=%b required %b", e.tag, k, q, e.q);
      end
`ifdef RUN_DETECT_FALL_EN
      n_checks++;
      if (qf !== e.qf) begin
        n_fail++;
        $display("FAIL %s step %0d: qf=%b required %b", e.tag, k, qf, e.qf);
      end
`endif
    end
  endtask

  task automatic test_broken_run();
    logic [3:0] iv [10] = '{4'h2, 4'h2, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
    logic [3:0] eq [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] ef [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0};
    exp_t e;
    run_len = 4'd3;
    for (int k = 0; k < 10; k++) begin
      drive(iv[k], eq[k], ef[k], "broken_run");
      e = sb.pop_front();
      n_checks++;
      if (q !== e.q) begin
        n_fail++;
        $display("FAIL %s step %0d: q=%b required %b", e.tag, k, q, e.q);
      end
`ifdef RUN_DETECT_FALL_EN
      n_checks++;
      if (qf !== e.qf) begin
        n_fail++;
        $display("FAIL %s step %0d: qf=%b required %b", e.tag, k, qf, e.qf);
      end
`endif
    end
  endtask

  task automatic test_len0();
    logic [3:0] iv [4] = '{4'h1, 4'h1, 4'h0, 4'h0};
    logic [3:0] eq [4] = '{4'h1, 4'h0, 4'h0, 4'h0};
    logic [3:0] ef [4] = '{4'h0, 4'h0, 4'h1, 4'h0};
    exp_t e;
    run_len = 4'd0;
    for (int k = 0; k < 4; k++) begin
      drive(iv[k], eq[k], ef[k], "len0");
      e = sb.pop_front();
      n_checks++;
      if (q !== e.q) begin
        n_fail++;
        $display("FAIL %s step %0d: q=%b required %b", e.tag, k, q, e.q);
      end
`ifdef RUN_DETECT_FALL_EN
      n_checks++;
      if (qf !== e.qf) begin
        n_fail++;
        $display("FAIL %s step %0d: qf=%b required %b", e.tag, k, qf, e.qf);
      end
`endif
    end
  endtask

  task automatic test_midrun_change();
    logic [3:0] iv [11] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
    logic [3:0] eq [11] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    logic [3:0] ef [11] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    exp_t e;
    run_len = 4'd3;
    for (int k = 0; k < 11; k++) begin
      if (k == 1) run_len = 4'd6;
      drive(iv[k], eq[k], ef[k], "midrun_len");
      e = sb.pop_front();
      n_checks++;
      if (q !== e.q) begin
        n_fail++;
        $display("FAIL %s step %0d: q=%b required %b", e.tag, k, q, e.q);
      end
`ifdef RUN_DETECT_FALL_EN
      n_checks++;
      if (qf !== e.qf) begin
        n_fail++;
        $display("FAIL %s step %0d: qf=%b required %b", e.tag, k, qf, e.qf);
      end
`endif
    end
  endtask

  task automatic test_pol_independent();
    logic [3:0] iv [6] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h5, 4'h0};
    logic [3:0] eq [6] = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h1, 4'h0};
    logic [3:0] ef [6] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h1};
    exp_t e;
    run_len = 4'd4;
    pol = 4'h4;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) pol = 4'h0;
      drive(iv[k], eq[k], ef[k], "pol_indep");
      e = sb.pop_front();
      n_checks++;
      if (q !== e.q) begin
        n_fail++;
        $display("FAIL %s step %0d: q=%b required %b", e.tag, k, q, e.q);
      end
`ifdef RUN_DETECT_FALL_EN
      n_checks++;
      if (qf !== e.qf) begin
        n_fail++;
        $display("FAIL %s step %0d: qf=%b required %b", e.tag, k, qf, e.qf);
      end
`endif
    end
  endtask

  task automatic test_reset_midrun();
    logic [3:0] eq [9] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0};
    exp_t e;
    run_len = 4'd3;
    for (int k = 0; k < 9; k++) begin
      if (k == 2) begin
        // Two samples counted; async reset must clear the count.
        reset = 1'b1;
        #1;
        n_checks++;
        if (q !== 4'h0 || qf !== 4'h0) begin
          n_fail++;
          $display("FAIL rst_count: q=%b qf=%b required 0000/0000", q, qf);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
      if (k == 5) begin
        reset = 1'b1;
        #1;
        n_checks++;
        if (q !== 4'h0 || qf !== 4'h0) begin
          n_fail++;
          $display("FAIL rst_fire: q=%b qf=%b required 0000/0000", q, qf);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
      drive(4'h1, eq[k], 4'h0, "rst_midrun");
      e = sb.pop_front();
      n_checks++;
      if (q !== e.q) begin
        n_fail++;
        $display("FAIL %s step %0d: q=%b required %b", e.tag, k, q, e.q);
      end
    end
    // Channel 0 now in HOLD; reset there must suppress the release pulse.
    reset = 1'b1;
    i = 4'h0;
    #1;
    n_checks++;
    if (q !== 4'h0 || qf !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_hold: q=%b qf=%b required 0000/0000", q, qf);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(4'h0, 4'h0, 4'h0, "rst_no_rel");
    e = sb.pop_front();
    n_checks++;
    if (q !== e.q || qf !== e.qf) begin
      n_fail++;
      $display("FAIL %s: q=%b qf=%b required %b/%b", e.tag, q, qf, e.q, e.qf);
    end
  endtask

  task automatic test_fall();
    logic [3:0] iv [8] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
    logic [3:0] eq [8] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] ef [8] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    exp_t e;
    run_len = 4'd2;
    for (int k = 0; k < 8; k++) begin
      drive(iv[k], eq[k], ef[k], "fall");
      e = sb.pop_front();
      n_checks++;
      if (q !== e.q) begin
        n_fail++;
        $display("FAIL %s step %0d: q=%b required %b", e.tag, k, q, e.q);
      end
`ifdef RUN_DETECT_FALL_EN
      n_checks++;
      if (qf !== e.qf) begin
        n_fail++;
        $display("FAIL %s step %0d: qf=%b required %b", e.tag, k, qf, e.qf);
      end
`endif
    end
  endtask

  // RUN_MAX=10 instance with run_len=15: nine samples fall short, ten fire.
  task automatic test_clamp();
    logic iv;
    logic ex;
    run_len2 = 4'd15;
    i = 4'h0;
    for (int k = 0; k < 21; k++) begin
      iv = (k < 9) || (k >= 10 && k < 20);
      ex = (k == 19);
      i2 = iv;
      sb2.push_back(ex);
      @(posedge clk);
      #1;
      ex = sb2.pop_front();
      n_checks++;
      if (q2 !== ex) begin
        n_fail++;
        $display("FAIL clamp step %0d: q2=%b required %b", k, q2, ex);
      end
    end
    i2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_len1();
    test_broken_run();
    test_len0();
    test_midrun_change();
    test_pol_independent();
    test_reset_midrun();
    test_fall();
    test_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
